// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART core: the FSM state type used by both the
// transmitter and the receiver, the oversampling constants and the baud
// divider calculation.
// Optional feature macro: UART_PARITY_EN (PARITY state is only entered when
// the macro is defined).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_MID = 8;

   // Rounded CLK_HZ / (OVERSAMPLE * BAUD), never below 2.
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
      return (d < 2) ? 2 : d;
   endfunction

endpackage

// File: rtl/uart_if.sv
// -----------------------------------------------------------------------------
// uart_if
// Parallel-side handshake bundle of the UART core.
//   tx_data/tx_valid/tx_ready : byte stream into the transmitter
//   rx_data/rx_valid/rx_ready : byte stream out of the receiver
//   rx_frame_err/rx_parity_err/rx_overrun : per-frame status, qualified by rx_valid
// Modports: master = bus/CPU side, slave = UART core side.
// -----------------------------------------------------------------------------
interface uart_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 rx_frame_err;
   logic                 rx_parity_err;
   logic                 rx_overrun;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
   );
endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing the x16 oversampling tick enable.
// Ports:
//   sysclk : system clock
//   rst_n  : synchronous active-low reset (counter returns to 0)
//   tick   : one-cycle pulse while the counter sits at DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DIV = 10
) (
   input  logic sysclk,
   input  logic rst_n,
   output logic tick
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == CNT_LAST);
endmodule

// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
// Full-duplex UART with x16 oversampling on a single clock.
// Ports:
//   sysclk   : system clock, all logic on the rising edge
//   rst_n    : synchronous active-low reset
//   bus      : uart_if.slave handshake bundle (TX in, RX out, RX status)
//   uart_rxd : asynchronous serial input
//   uart_txd : registered serial output, idle high
// Build option: define UART_PARITY_EN to add a parity bit (even, or odd
// when PARITY_ODD=1) to both directions; otherwise rx_parity_err is 0.
// -----------------------------------------------------------------------------
module uart_core
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic  sysclk,
   input  logic  rst_n,
   uart_if.slave bus,
   input  logic  uart_rxd,
   output logic  uart_txd
);
   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_LAST  = 4'(SAMPLE_MID - 1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
      $error("uart_core: illegal DATA_BITS/STOP_BITS/PARITY_ODD");
   end

`ifdef UART_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

   logic tick;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .tick   (tick)
   );

   // ---------------------------------------------------------------- TX
   uart_state_t          tx_state;
   logic [3:0]           tx_tcnt;
   logic [3:0]           tx_bcnt;
   logic [DATA_BITS-1:0] tx_shreg;
   logic                 tx_ready_q;
   logic                 txd_q;
`ifdef UART_PARITY_EN
   logic                 tx_par;
`endif

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         tx_state   <= IDLE;
         tx_tcnt    <= '0;
         tx_bcnt    <= '0;
         tx_ready_q <= 1'b1;
         txd_q      <= 1'b1;
      end else begin
         case (tx_state)
            IDLE: begin
               // tx_ready is high throughout IDLE, so tx_valid alone is the handshake.
               if (bus.tx_valid) begin
                  tx_shreg   <= bus.tx_data;
`ifdef UART_PARITY_EN
                  tx_par     <= (^bus.tx_data) ^ PAR_ODD;
`endif
                  tx_tcnt    <= '0;
                  tx_bcnt    <= '0;
                  tx_ready_q <= 1'b0;
                  txd_q      <= 1'b0;
                  tx_state   <= START;
               end
            end
            default: begin
               if (tick) begin
                  if (tx_tcnt != TICK_LAST) begin
                     tx_tcnt <= tx_tcnt + 4'd1;
                  end else begin
                     tx_tcnt <= '0;
                     case (tx_state)
                        START: begin
                           txd_q    <= tx_shreg[0];
                           tx_shreg <= tx_shreg >> 1;
                           tx_state <= DATA;
                        end
                        DATA: begin
                           if (tx_bcnt != DATA_LAST) begin
                              txd_q    <= tx_shreg[0];
                              tx_shreg <= tx_shreg >> 1;
                              tx_bcnt  <= tx_bcnt + 4'd1;
                           end else begin
                              tx_bcnt  <= '0;
`ifdef UART_PARITY_EN
                              txd_q    <= tx_par;
                              tx_state <= PARITY;
`else
                              txd_q    <= 1'b1;
                              tx_state <= STOP;
`endif
                           end
                        end
`ifdef UART_PARITY_EN
                        PARITY: begin
                           txd_q    <= 1'b1;
                           tx_state <= STOP;
                        end
`endif
                        STOP: begin
                           // tx_bcnt counts stop bits here.
                           if (tx_bcnt != STOP_LAST) begin
                              tx_bcnt <= tx_bcnt + 4'd1;
                           end else begin
                              tx_ready_q <= 1'b1;
                              tx_state   <= IDLE;
                           end
                        end
                        default: begin
                           txd_q      <= 1'b1;
                           tx_ready_q <= 1'b1;
                           tx_state   <= IDLE;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX
   logic                 rxd_p0;
   logic                 rxd_p1;
   uart_state_t          rx_state;
   logic [3:0]           rx_tcnt;
   logic [3:0]           rx_bcnt;
   logic [DATA_BITS-1:0] rx_shreg;
   logic                 rx_armed;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 rx_ferr_q;
   logic                 rx_ovr_q;
`ifdef UART_PARITY_EN
   logic                 rx_par_err;
   logic                 rx_perr_q;
`endif

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         rxd_p0     <= 1'b1;
         rxd_p1     <= 1'b1;
         rx_state   <= IDLE;
         rx_tcnt    <= '0;
         rx_bcnt    <= '0;
         rx_armed   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         rxd_p0 <= uart_rxd;
         rxd_p1 <= rxd_p0;

         // Consume; a frame completing in the same cycle overrides below.
         if (rx_valid_q && bus.rx_ready) begin
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
         end

         case (rx_state)
            IDLE: begin
               // A start needs a high level since the last frame, so a stuck-low
               // line produces a single frame rather than a stream of them.
               if (rxd_p1) begin
                  rx_armed <= 1'b1;
               end else if (tick && rx_armed) begin
                  rx_armed <= 1'b0;
                  rx_tcnt  <= '0;
                  rx_state <= START;
               end
            end
            default: begin
               if (tick) begin
                  if (rx_tcnt != ((rx_state == START) ? MID_LAST : TICK_LAST)) begin
                     rx_tcnt <= rx_tcnt + 4'd1;
                  end else begin
                     rx_tcnt <= '0;
                     case (rx_state)
                        START: begin
                           if (rxd_p1) begin
                              rx_state <= IDLE;
                           end else begin
                              rx_bcnt  <= '0;
                              rx_state <= DATA;
                           end
                        end
                        DATA: begin
                           rx_shreg <= {rxd_p1, rx_shreg[DATA_BITS-1:1]};
                           if (rx_bcnt != DATA_LAST) begin
                              rx_bcnt <= rx_bcnt + 4'd1;
                           end else begin
`ifdef UART_PARITY_EN
                              rx_state <= PARITY;
`else
                              rx_state <= STOP;
`endif
                           end
                        end
`ifdef UART_PARITY_EN
                        PARITY: begin
                           rx_par_err <= rxd_p1 != ((^rx_shreg) ^ PAR_ODD);
                           rx_state   <= STOP;
                        end
`endif
                        STOP: begin
                           rx_data_q  <= rx_shreg;
                           rx_valid_q <= 1'b1;
                           rx_ferr_q  <= ~rxd_p1;
                           rx_ovr_q   <= rx_valid_q && !bus.rx_ready;
`ifdef UART_PARITY_EN
                           rx_perr_q  <= rx_par_err;
`endif
                           rx_state   <= IDLE;
                        end
                        default: rx_state <= IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign bus.tx_ready     = tx_ready_q;
   assign uart_txd         = txd_q;
   assign bus.rx_data      = rx_data_q;
   assign bus.rx_valid     = rx_valid_q;
   assign bus.rx_frame_err = rx_ferr_q;
   assign bus.rx_overrun   = rx_ovr_q;
`ifdef UART_PARITY_EN
   assign bus.rx_parity_err = rx_perr_q;
`else
   assign bus.rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// -----------------------------------------------------------------------------
// tb_uart_core
// Self-checking bench for uart_core at CLK_HZ=1.6 MHz, BAUD=10 kHz (one bit =
// 160 clocks). Serial frames are built and decoded from the line format alone;
// received frames are collected by a monitor and compared with expected records.
// Honours UART_PARITY_EN (even parity).
// -----------------------------------------------------------------------------
module tb_uart_core;
   localparam int CLK_HZ  = 1600000;
   localparam int BAUD    = 10000;
   localparam int DB      = 8;
   localparam int SB      = 1;
   localparam int BIT_CYC = 160;
   localparam int TB_DIV  = 10;
`ifdef UART_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB          = DB + PAR + 1;
   localparam int FRAME_TICKS = 16 * (1 + DB + PAR + SB);

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
      logic       ovr;
   } rx_rec_t;
   typedef bit bitq_t[$];

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;
   logic rxd_drv = 1'b1;
   logic loop   = 1'b0;
   logic uart_rxd;
   logic uart_txd;

   uart_if #(.DATA_BITS(DB)) bus();

   assign uart_rxd = loop ? uart_txd : rxd_drv;

   uart_core #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .DATA_BITS  (DB),
      .STOP_BITS  (SB),
      .PARITY_ODD (0)
   ) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .uart_rxd (uart_rxd),
      .uart_txd (uart_txd)
   );

   always #5 sysclk = ~sysclk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge sysclk);
         #2;
      end
   endtask

   // Received-frame monitor: records every frame at the moment it is consumed.
   rx_rec_t got_q[$];
   always @(negedge sysclk) begin
      if (rst_n && bus.rx_valid && bus.rx_ready)
         got_q.push_back({bus.rx_data, bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun});
   end

   function automatic logic even_par(input logic [7:0] b);
      return ($countones(b) % 2) == 1;
   endfunction

   function automatic rx_rec_t rec(input logic [7:0] d, input logic f, input logic p, input logic o);
      rx_rec_t r;
      r.data = d; r.ferr = f; r.perr = p; r.ovr = o;
      return r;
   endfunction

   // Line-level frame: start, data LSB first, [parity], one stop bit.
   function automatic bitq_t make_frame(input logic [7:0] b, input logic stop_v);
      bitq_t q;
      q.push_back(1'b0);
      for (int i = 0; i < DB; i++) q.push_back(b[i]);
`ifdef UART_PARITY_EN
      q.push_back(even_par(b));
`endif
      q.push_back(stop_v);
      return q;
   endfunction

   task automatic send_bits(input bitq_t q);
      foreach (q[i]) begin
         rxd_drv = q[i];
         step(BIT_CYC);
      end
   endtask

   task automatic expect_rx(input string tag, input rx_rec_t exp_q[$]);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.tx_ready && n < 4000) begin
         step();
         n++;
      end
      check(tag, bus.tx_ready, 1);
   endtask

   // Sends one byte and decodes the line: fr[k] is the value at the centre of
   // bit k after the start bit (data, [parity], stop).
   task automatic tx_send(input logic [7:0] b, output logic [NB-1:0] fr,
                          output int low_cyc, output int start_len);
      logic txd_log [0:4095];
      int n;
      wait_ready("tx_idle");
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      n = 1;
      low_cyc = 0;
      while (n < 4000) begin
         txd_log[n] = uart_txd;
         if (bus.tx_ready) break;
         low_cyc++;
         step();
         n++;
      end
      check("tx_ready_return", bus.tx_ready, 1);
      start_len = 0;
      for (int i = 1; i < n && txd_log[i] == 1'b0; i++) start_len++;
      for (int k = 0; k < NB; k++) fr[k] = txd_log[236 + BIT_CYC * k];
   endtask

   logic [7:0]    b;
   logic [NB-1:0] fr;
   int            low_cyc;
   int            start_len;
   rx_rec_t       exp_q[$];

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b1;

      // Reset state, with a transmit request that must be ignored.
      rst_n = 1'b0;
      step(3);
      bus.tx_valid = 1'b1;
      step(3);
      check("rst_txd", uart_txd, 1);
      check("rst_tx_ready", bus.tx_ready, 1);
      check("rst_rx_valid", bus.rx_valid, 0);
      check("rst_rx_data", bus.rx_data, 0);
      check("rst_flags", {bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun}, 0);
      bus.tx_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step(20);
      check("idle_txd", uart_txd, 1);

      // Transmit: 0xA5 then random bytes.
      for (int t = 0; t < 4; t++) begin
         b = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         tx_send(b, fr, low_cyc, start_len);
         check("tx_data", fr[DB-1:0], b);
         check("tx_stop", fr[NB-1], 1);
`ifdef UART_PARITY_EN
         check("tx_parity", fr[DB], even_par(b));
`endif
         check("tx_ready_low", (low_cyc >= FRAME_TICKS * TB_DIV - (TB_DIV - 1)) &&
                               (low_cyc <= FRAME_TICKS * TB_DIV), 1);
         if (b[0]) check("tx_start_len", (start_len >= BIT_CYC - (TB_DIV - 1)) &&
                                         (start_len <= BIT_CYC), 1);
         step(30);
         check("tx_idle_high", uart_txd, 1);
      end

      // Receive random well-formed frames.
      got_q.delete();
      exp_q.delete();
      for (int t = 0; t < 4; t++) begin
         b = 8'($urandom_range(0, 255));
         send_bits(make_frame(b, 1'b1));
         rxd_drv = 1'b1;
         exp_q.push_back(rec(b, 1'b0, 1'b0, 1'b0));
         step($urandom_range(5, 60));
      end
      expect_rx("rx_random", exp_q);

      // Loopback, back-to-back 0x3C, 0xC3.
      loop = 1'b1;
      step(50);
      got_q.delete();
      wait_ready("loop_ready0");
      bus.tx_data  = 8'h3C;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_data  = 8'hC3;
      wait_ready("loop_ready1");
      step();
      bus.tx_valid = 1'b0;
      wait_ready("loop_ready2");
      step(200);
      loop = 1'b0;
      exp_q.delete();
      exp_q.push_back(rec(8'h3C, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(rec(8'hC3, 1'b0, 1'b0, 1'b0));
      expect_rx("loopback", exp_q);

      // 50-cycle glitch is a false start; the next frame is still received.
      got_q.delete();
      rxd_drv = 1'b0;
      step(50);
      rxd_drv = 1'b1;
      step(300);
      check("false_start_silent", got_q.size(), 0);
      send_bits(make_frame(8'h55, 1'b1));
      rxd_drv = 1'b1;
      step(50);
      exp_q.delete();
      exp_q.push_back(rec(8'h55, 1'b0, 1'b0, 1'b0));
      expect_rx("after_false_start", exp_q);

      // Stop bit low, line held low: one frame with frame_err only.
      got_q.delete();
      send_bits(make_frame(8'h12, 1'b0));
      step(2000);
      exp_q.delete();
      exp_q.push_back(rec(8'h12, 1'b1, 1'b0, 1'b0));
      expect_rx("frame_err_held_low", exp_q);
      rxd_drv = 1'b1;
      step(320);
      send_bits(make_frame(8'h5A, 1'b1));
      rxd_drv = 1'b1;
      step(50);
      exp_q.push_back(rec(8'h5A, 1'b0, 1'b0, 1'b0));
      expect_rx("after_line_high", exp_q);

      // Overrun with rx_ready low, then consume.
      bus.rx_ready = 1'b0;
      send_bits(make_frame(8'h11, 1'b1));
      rxd_drv = 1'b1;
      step(40);
      check("ovr_first_valid", bus.rx_valid, 1);
      check("ovr_first_flag", bus.rx_overrun, 0);
      send_bits(make_frame(8'h22, 1'b1));
      rxd_drv = 1'b1;
      step(40);
      check("ovr_valid", bus.rx_valid, 1);
      check("ovr_data", bus.rx_data, 8'h22);
      check("ovr_flag", bus.rx_overrun, 1);
      check("ovr_ferr", bus.rx_frame_err, 0);
      bus.rx_ready = 1'b1;
      step();
      bus.rx_ready = 1'b0;
      check("consume_valid", bus.rx_valid, 0);
      check("consume_flags", {bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun}, 0);
      bus.rx_ready = 1'b1;
      step(20);

`ifdef UART_PARITY_EN
      // Parity: TX 0x07 carries parity 1; RX 0x07 with parity 0 flags an error.
      tx_send(8'h07, fr, low_cyc, start_len);
      check("tx07_parity", fr[DB], 1);
      check("tx07_data", fr[DB-1:0], 8'h07);
      got_q.delete();
      begin
         bitq_t q;
         q = make_frame(8'h07, 1'b1);
         q[1 + DB] = 1'b0;
         send_bits(q);
      end
      rxd_drv = 1'b1;
      step(50);
      exp_q.delete();
      exp_q.push_back(rec(8'h07, 1'b0, 1'b1, 1'b0));
      expect_rx("rx_parity_err", exp_q);
`endif

      // Reset in the middle of a transmitted frame.
      wait_ready("mid_rst_ready");
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      step(500);
      check("mid_tx_low", uart_txd, 0);
      rst_n = 1'b0;
      step();
      check("mid_rst_txd", uart_txd, 1);
      check("mid_rst_ready", bus.tx_ready, 1);
      step(3);
      rst_n = 1'b1;
      step(10);
      check("post_rst_txd", uart_txd, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART for the CPU's serial port, replacing the fixed 9600-8N1 unit.
- Single clock domain with a shared x16 tick enable; no derived clocks.
- Configurable baud, data width and stop bits; valid/ready handshakes on both directions; RX error reporting.
- Sits between the memory-mapped peripheral bus and the board's serial pins.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = round(CLK_HZ/(16*BAUD)), minimum 2
DATA_BITS, 8, payload width, legal range 5..8
STOP_BITS, 1, TX stop bits, 1 or 2
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only with UART_PARITY_EN

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
tx_data  in  DATA_BITS  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter idle; transfer occurs when tx_valid && tx_ready
rx_data  out  DATA_BITS  received byte
rx_valid  out  1  rx_data and error flags valid; held until consumed
rx_ready  in  1  consumer accepts rx_data
rx_frame_err  out  1  stop bit sampled low, qualified by rx_valid
rx_parity_err  out  1  parity mismatch, qualified by rx_valid
rx_overrun  out  1  unread frame overwritten, qualified by rx_valid
uart_rxd  in  1  serial input, asynchronous
uart_txd  out  1  serial output, idle high

Behaviour:
- Reset values while rst_n=0: uart_txd=1, tx_ready=1 (acceptance ignored), rx_valid=0, all error flags=0, rx_data=0, both FSMs IDLE, tick counter=0, synchroniser flops=1. Reset mid-frame aborts the frame immediately; txd returns high on the same edge.
- Tick generator: counter runs 0..DIV-1 and wraps. tick=1 for one cycle when counter==DIV-1. Free-running; shared by TX and RX. One bit = 16 ticks.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - tx_ready=1 only in IDLE.
  - On accept: latch tx_data, clear the tick sub-count, enter START; uart_txd=0 from the next edge.
  - Each state lasts until its 16th tick. The start bit is therefore 16 ticks minus up to DIV-1 cycles.
  - Data is sent LSB first, DATA_BITS bits. STOP drives 1 for 16*STOP_BITS ticks.
  - tx_ready rises on the cycle after the final stop tick. tx_valid held continuously gives back-to-back frames.
- RX input: two-flop synchroniser. All sampling uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE detects a start on a tick with rxd=0, but only if rxd was seen 1 since the last frame (edge qualification; a held-low line yields one frame only).
  - START: on the 8th tick after detection (mid-bit), rxd=1 -> false start, return to IDLE, no output. Otherwise continue.
  - Each later bit is sampled 16 ticks after the previous sample. Data is assembled LSB first.
  - STOP: exactly one stop bit is sampled regardless of STOP_BITS. rxd=0 sets frame_err.
  - On the stop-sample cycle: rx_data, error flags and rx_valid=1 update on the next edge, and the FSM returns to IDLE for back-to-back reception.
- RX handshake:
  - rx_valid && rx_ready clears rx_valid and all flags on the next edge.
  - New frame completes while rx_valid=1 and rx_ready=0: rx_data and flags are overwritten, rx_overrun=1.
  - Completion and consume in the same cycle: new data loaded, rx_valid stays 1, rx_overrun=0.
- TX and RX are fully independent. uart_txd is registered.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: one parity bit follows the data on both TX and RX, even or odd per PARITY_ODD. An RX mismatch sets rx_parity_err (frame still delivered).
- Undefined: no PARITY state in either FSM, rx_parity_err tied 0, PARITY_ODD ignored.

Decomposition:
- Package uart_pkg holds: the TX/RX state enum typedef (IDLE, START, DATA, PARITY, STOP), OVERSAMPLE=16, SAMPLE_MID=8, and a function computing DIV from CLK_HZ/BAUD.
- One sub-module: uart_baud_tick (counter plus tick pulse, parameter DIV).
- TX and RX FSMs live in uart_core.

Test Plan:
- Bench uses CLK_HZ=1600000, BAUD=10000, so DIV=10 and one bit = 160 cycles.
- TX 0xA5, 8N1: txd low ~160 cycles, then 1,0,1,0,0,1,0,1, then high. tx_ready low for 1591..1600 cycles.
- Loopback txd->rxd, 0x3C then 0xC3 back-to-back with rx_ready=1: two rx_valid pulses, data 0x3C then 0xC3, all error flags 0.
- rxd low pulse of 50 cycles while idle: no rx_valid, and a following valid frame 0x55 is received correctly.
- Frame 0x12 with stop bit driven 0, then line held low: one rx_valid with frame_err=1. No further frame until rxd returns high.
- Frames 0x11 then 0x22 with rx_ready=0: rx_data=0x22, rx_overrun=1. Pulse rx_ready: rx_valid=0 and flags=0 on the next cycle. Reset asserted mid-TX: txd=1 on the next edge.
- With UART_PARITY_EN and PARITY_ODD=0: TX 0x07 emits parity bit 1. RX 0x07 with parity bit 0 gives rx_valid, rx_data=0x07, rx_parity_err=1.
